// File: rtl/mult_div_seq_pkg.sv
// ---------------------------------------------------------------------------
// mult_div_seq_pkg: shared MULT/DIV sequencer state encoding.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mult_div_seq_pkg;

   localparam int MD_ITER = 32;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      MULT_RUN = 3'd1,
      DIV_RUN  = 3'd2,
      DIV_ZERO = 3'd3,
      FINISH   = 3'd4
   } md_state_t;

endpackage

`default_nettype wire

// File: rtl/mult_div_seq_sign_fix.sv
// ---------------------------------------------------------------------------
// mult_div_seq_sign_fix: conditional two's-complement negate.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mult_div_seq_sign_fix #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] value,
   input  logic             negate,
   output logic [WIDTH-1:0] result
);

   assign result = negate ? (~value + WIDTH'(1)) : value;

endmodule

`default_nettype wire

// File: rtl/mult_div_seq.sv
// ---------------------------------------------------------------------------
// mult_div_seq: signed MULT/DIV sequencer (shift-add / restoring). Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mult_div_seq
   import mult_div_seq_pkg::*;
#(
   parameter int WIDTH = MD_ITER,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_mult,
   input  logic             start_div,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic             hilo_write,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out
);

   md_state_t          state;
   logic [CNT_W-1:0]   cnt;
   logic               is_div;
   logic               sign_a;
   logic               sign_b;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   opb_mag;

   logic [WIDTH-1:0]   abs_a;
   logic [WIDTH-1:0]   abs_b;
   logic [WIDTH-1:0]   quot_fix;
   logic [WIDTH-1:0]   rem_fix;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH:0]     trial;
   logic               last_iter;

   mult_div_seq_sign_fix #(.WIDTH(WIDTH)) u_abs_a (
      .value(op_a), .negate(op_a[WIDTH-1]), .result(abs_a));
   mult_div_seq_sign_fix #(.WIDTH(WIDTH)) u_abs_b (
      .value(op_b), .negate(op_b[WIDTH-1]), .result(abs_b));
   mult_div_seq_sign_fix #(.WIDTH(2*WIDTH)) u_fix_prod (
      .value(acc), .negate(sign_a ^ sign_b), .result(prod_fix));
   mult_div_seq_sign_fix #(.WIDTH(WIDTH)) u_fix_quot (
      .value(acc[WIDTH-1:0]), .negate(sign_a ^ sign_b), .result(quot_fix));
   mult_div_seq_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
      .value(acc[2*WIDTH-1:WIDTH]), .negate(sign_a), .result(rem_fix));

   // Divide keeps remainder:quotient in acc; trial uses the shifted remainder plus its carry-out bit.
   assign trial     = {acc[2*WIDTH-1], acc[2*WIDTH-2:WIDTH-1]} - {1'b0, opb_mag};
   assign last_iter = (cnt == CNT_W'(WIDTH-1));
   assign busy      = (state != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         is_div     <= 1'b0;
         sign_a     <= 1'b0;
         sign_b     <= 1'b0;
         acc        <= '0;
         mcand      <= '0;
         opb_mag    <= '0;
         done       <= 1'b0;
         div_zero   <= 1'b0;
         hilo_write <= 1'b0;
         hi_out     <= '0;
         lo_out     <= '0;
      end else begin
         done       <= 1'b0;
         div_zero   <= 1'b0;
         hilo_write <= 1'b0;
         case (state)
            IDLE: begin
               if (start_mult || start_div) begin
                  sign_a  <= op_a[WIDTH-1];
                  sign_b  <= op_b[WIDTH-1];
                  cnt     <= '0;
                  opb_mag <= abs_b;
                  is_div  <= !start_mult;
                  if (start_mult) begin
                     acc   <= '0;
                     mcand <= {{WIDTH{1'b0}}, abs_a};
                     state <= MULT_RUN;
                  end else if (op_b == '0) begin
                     state <= DIV_ZERO;
                  end else begin
                     acc   <= {{WIDTH{1'b0}}, abs_a};
                     state <= DIV_RUN;
                  end
               end
            end
            MULT_RUN: begin
               acc     <= acc + (opb_mag[0] ? mcand : '0);
               mcand   <= mcand << 1;
               opb_mag <= opb_mag >> 1;
               cnt     <= cnt + CNT_W'(1);
               if (last_iter) state <= FINISH;
            end
            DIV_RUN: begin
               if (!trial[WIDTH])
                  acc <= {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
               else
                  acc <= {acc[2*WIDTH-2:0], 1'b0};
               cnt <= cnt + CNT_W'(1);
               if (last_iter) state <= FINISH;
            end
            DIV_ZERO: begin
               done     <= 1'b1;
               div_zero <= 1'b1;
               state    <= IDLE;
            end
            FINISH: begin
               if (is_div) begin
                  hi_out <= rem_fix;
                  lo_out <= quot_fix;
               end else begin
                  {hi_out, lo_out} <= prod_fix;
               end
               done       <= 1'b1;
               hilo_write <= 1'b1;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mult_div_seq.sv
// ---------------------------------------------------------------------------
// tb_mult_div_seq: vector table, corner sequences and random ops vs a model.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mult_div_seq;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start_mult = 1'b0;
   logic        start_div = 1'b0;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic        busy, done, div_zero, hilo_write;
   logic [31:0] hi_out, lo_out;

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt = 0;

   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;
   logic        m_dz = 1'b0;

   typedef struct {
      logic        m;
      logic        d;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      string       name;
   } vec_t;

   vec_t vecs[8];

   mult_div_seq dut (
      .clk(clk), .reset(reset), .start_mult(start_mult), .start_div(start_div),
      .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .div_zero(div_zero),
      .hilo_write(hilo_write), .hi_out(hi_out), .lo_out(lo_out));

   always #5 clk = ~clk;

   always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: signed 64-bit arithmetic, truncating division; HI/LO unchanged on divide by zero.
   task automatic ref_op(input logic m, input logic [31:0] a, input logic [31:0] b);
      longint p, q, r;
      if (m) begin
         p = longint'($signed(a)) * longint'($signed(b));
         m_hi = p[63:32];
         m_lo = p[31:0];
         m_dz = 1'b0;
      end else if (b == 32'd0) begin
         m_dz = 1'b1;
      end else begin
         q = longint'($signed(a)) / longint'($signed(b));
         r = longint'($signed(a)) % longint'($signed(b));
         m_hi = r[31:0];
         m_lo = q[31:0];
         m_dz = 1'b0;
      end
   endtask

   task automatic do_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic busy_gap, output logic busy_at_done);
      @(negedge clk);
      start_mult = m; start_div = d; op_a = a; op_b = b;
      @(negedge clk);
      start_mult = 1'b0; start_div = 1'b0; op_a = $urandom; op_b = $urandom;
      lat = 0;
      busy_gap = 1'b0;
      busy_at_done = 1'b1;
      while (lat < 100) begin
         @(negedge clk);
         lat++;
         if (done === 1'b1) begin
            busy_at_done = busy;
            break;
         end
         if (busy !== 1'b1) busy_gap = 1'b1;
      end
   endtask

   task automatic check_op(input string name, input logic m, input logic d,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
      int   lat;
      logic gap, bd;
      do_op(m, d, a, b, lat, gap, bd);
      check({name, ".latency"}, 64'(lat), edz ? 64'd1 : 64'd33);
      check({name, ".busy_run"}, 64'(gap), 64'd0);
      check({name, ".busy_done"}, 64'(bd), 64'd0);
      check({name, ".div_zero"}, 64'(div_zero), 64'(edz));
      check({name, ".hilo_write"}, 64'(hilo_write), 64'(!edz));
      check({name, ".hi"}, 64'(hi_out), 64'(ehi));
      check({name, ".lo"}, 64'(lo_out), 64'(elo));
      @(negedge clk);
      check({name, ".done_clear"}, 64'({done, div_zero, hilo_write}), 64'd0);
   endtask

   initial begin
      int          lat, dc0;
      logic        gap, bd, m;
      logic [31:0] a, b;

      vecs[0] = '{1'b1, 1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, "mul_7_m3"};
      vecs[1] = '{1'b1, 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, "mul_min_min"};
      vecs[2] = '{1'b0, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "div_m7_2"};
      vecs[3] = '{1'b0, 1'b1, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, "div_100_7"};
      vecs[4] = '{1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, "div_min_m1"};
      vecs[5] = '{1'b0, 1'b1, 32'h451,      32'h20,       32'h11,       32'h22,       1'b0, "div_prep"};
      vecs[6] = '{1'b0, 1'b1, 32'd5,        32'd0,        32'h11,       32'h22,       1'b1, "div_5_0"};
      vecs[7] = '{1'b1, 1'b1, 32'd3,        32'd4,        32'd0,        32'd12,       1'b0, "both_start"};

      repeat (3) @(negedge clk);
      check("reset.outputs", 64'({busy, done, div_zero, hilo_write}), 64'd0);
      check("reset.hilo", {hi_out, lo_out}, 64'd0);
      reset = 1'b0;

      for (int i = 0; i < 8; i++) begin
         check_op(vecs[i].name, vecs[i].m, vecs[i].d, vecs[i].a, vecs[i].b,
                  vecs[i].hi, vecs[i].lo, vecs[i].dz);
         ref_op(vecs[i].m, vecs[i].a, vecs[i].b);
      end

      // Start pulse while busy must be ignored.
      dc0 = done_cnt;
      @(negedge clk);
      start_mult = 1'b1; start_div = 1'b1; op_a = 32'd3; op_b = 32'd4;
      @(negedge clk);
      start_mult = 1'b0; start_div = 1'b0;
      repeat (9) @(negedge clk);
      start_div = 1'b1; op_a = 32'd100; op_b = 32'd7;
      @(negedge clk);
      start_div = 1'b0;
      lat = 10;
      while (lat < 100) begin
         @(negedge clk);
         lat++;
         if (done === 1'b1) break;
      end
      check("ignore_start.latency", 64'(lat), 64'd33);
      check("ignore_start.hilo", {hi_out, lo_out}, 64'd12);
      repeat (40) @(negedge clk);
      check("ignore_start.done_count", 64'(done_cnt - dc0), 64'd1);
      ref_op(1'b1, 32'd3, 32'd4);

      // Reset mid-multiply at edge N+15.
      @(negedge clk);
      start_mult = 1'b1; op_a = 32'd1234; op_b = 32'd5678;
      @(negedge clk);
      start_mult = 1'b0;
      repeat (14) @(negedge clk);
      reset = 1'b1;
      dc0 = done_cnt;
      @(negedge clk);
      check("midreset.busy", 64'(busy), 64'd0);
      check("midreset.flags", 64'({done, div_zero, hilo_write}), 64'd0);
      check("midreset.hilo", {hi_out, lo_out}, 64'd0);
      reset = 1'b0;
      repeat (40) @(negedge clk);
      check("midreset.no_done", 64'(done_cnt - dc0), 64'd0);
      m_hi = '0; m_lo = '0;
      check_op("after_reset", 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd1, 1'b0);
      ref_op(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);

      for (int i = 0; i < 40; i++) begin
         m = 1'($urandom_range(0, 1));
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: a = 32'h80000000;
            2: b = 32'($urandom_range(1, 9));
            3: b = 32'hFFFFFFFF;
            default: ;
         endcase
         ref_op(m, a, b);
         do_op(m, !m, a, b, lat, gap, bd);
         check("rand.latency", 64'(lat), m_dz ? 64'd1 : 64'd33);
         check("rand.flags", 64'({div_zero, hilo_write, bd}), 64'({m_dz, !m_dz, 1'b0}));
         check("rand.hilo", {hi_out, lo_out}, {m_hi, m_lo});
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mult_div_seq.md
Name: mult_div_seq

Overview:
- Multi-cycle sequencer for the MULT/DIV instructions of the multicycle MIPS core.
- Accepts a start pulse from the main control FSM and runs a shift-add multiplier or a restoring divider, one iteration per cycle.
- Flags divide-by-zero and produces a HI/LO write strobe.
- The main control FSM stalls in a wait state until done is seen.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start_mult  in  1  begin signed multiply of op_a*op_b
- start_div  in  1  begin signed divide op_a/op_b
- op_a  in  WIDTH  rs value (from reg A)
- op_b  in  WIDTH  rt value (from reg B)
- busy  out  1  operation in progress (state != IDLE)
- done  out  1  one-cycle completion pulse
- div_zero  out  1  one-cycle pulse, coincident with done, for divide by zero
- hilo_write  out  1  one-cycle pulse; HI/LO register file load enable
- hi_out  out  WIDTH  HI result (mult: upper product; div: remainder)
- lo_out  out  WIDTH  LO result (mult: lower product; div: quotient)

Behaviour:
- Reset is synchronous and active-high on clk and overrides everything, including mid-operation.
  - state=IDLE; counter=0.
  - busy, done, div_zero, hilo_write = 0.
  - hi_out = lo_out = 0.
  - The aborted operation produces no done.
- States: IDLE, MULT_RUN, DIV_RUN, DIV_ZERO, FINISH.
- IDLE: start is sampled only here; starts seen while busy are ignored. If start_mult and start_div are both high, multiply wins. On the start edge N:
  - Latch |op_a| and |op_b| and both sign bits.
  - Clear the accumulator and the counter.
  - Go to MULT_RUN, or to DIV_RUN. A divide with op_b==0 goes to DIV_ZERO instead.
- MULT_RUN (edges N+1..N+WIDTH): one shift-add step per edge on the 2*WIDTH-bit accumulator; counter+1. When counter reaches WIDTH-1, go to FINISH.
- DIV_RUN (edges N+1..N+WIDTH): one restoring step per edge.
  - Shift remainder:quotient left.
  - Trial-subtract the divisor; keep the result if non-negative and set the quotient bit.
  - counter+1. At WIDTH-1, go to FINISH.
- Sign fixup:
  - Product is negated (2*WIDTH two's complement) if sign_a^sign_b.
  - Quotient is negated if sign_a^sign_b; remainder is negated if sign_a (truncation toward zero, MIPS semantics).
  - Arithmetic wraps modulo 2^WIDTH. Example: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- FINISH, edge N+WIDTH+1: register the sign-fixed hi_out/lo_out; done=1, hilo_write=1; state goes to IDLE.
- DIV_ZERO, edge N+1: done=1, div_zero=1, hilo_write=0; hi_out/lo_out hold their previous values; state goes to IDLE.
- done, div_zero and hilo_write return to 0 on the following edge.
- busy is low in the done cycle, so a new start may be accepted on that same edge.
- hi_out/lo_out hold their value until the next successful completion or reset.
- Latency: start edge N, done high during the cycle after edge N+33 for WIDTH=32. Divide-by-zero: done after edge N+1.

Decomposition:
- Shared package (cpu_pkg): state encoding constants, MD_ITER=WIDTH. The main control FSM uses the same package for its MULT_WAIT/DIV_WAIT states.
- Sub-module: none required. Optionally md_sign_fix, a combinational negate/abs helper instantiated twice (abs on entry, fixup on exit).

Test Plan:
- Multiply 7 * 0xFFFFFFFD (-3), start_mult at edge N -> done and hilo_write high after edge N+33; HI=0xFFFFFFFF, LO=0xFFFFFFEB; busy high for cycles N+1..N+33.
- Multiply 0x80000000 * 0x80000000 -> HI=0x40000000, LO=0x00000000.
- Divide 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Divide 100/7 -> LO=14, HI=2.
- Divide 5/0 with prior HI/LO=0x11/0x22 -> done and div_zero high one cycle after edge N+1; hilo_write=0; HI/LO stay 0x11/0x22.
- Simultaneous start_mult and start_div (3, 4) -> multiply executes: LO=12, HI=0. A start pulse at edge N+10 is ignored, and exactly one done is produced.
- Reset asserted at edge N+15 of a multiply -> next cycle busy=0, hi_out=lo_out=0, no done. A fresh start afterwards completes normally in 33 cycles.
